// File: rtl/softmax_norm_ctrl.sv
// Softmax row normalizer: buffers and sums one row of exp values, then drives an
// external divider element by element and streams the quotients out in input order.
module softmax_norm_ctrl #(
    parameter int D_W     = 16,
    parameter int ROW_LEN = 8,
    parameter int SUM_W   = D_W + $clog2(ROW_LEN)
) (
    input  logic           I_CLK,
    input  logic           I_RST,
    input  logic           I_EXP_VLD,
    input  logic [D_W-1:0] I_EXP_DATA,
    output logic           O_EXP_RDY,
    output logic           O_DIV_START,
    output logic [D_W-1:0] O_DIVIDEND,
    output logic [D_W-1:0] O_DIVISOR,
    input  logic           I_DIV_VLD,
    input  logic [D_W-1:0] I_QUOTIENT,
    output logic           O_PROB_VLD,
    output logic [D_W-1:0] O_PROB_DATA,
    output logic           O_PROB_LAST,
    output logic           O_BUSY
);
    localparam int               IDX_W      = $clog2(ROW_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROW_LEN - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(ROW_LEN - 2);
    localparam logic [SUM_W-1:0] SAT_MAX    = SUM_W'({1'b0, {(D_W-1){1'b1}}});

    typedef enum logic [2:0] {
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_ZERO
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SUM_W-1:0] sum_q, sum_d, sum_acc;
    logic [D_W-1:0]   divisor_q, divisor_d;
    logic [D_W-1:0]   exp_buf_q [ROW_LEN];
    logic [D_W-1:0]   exp_buf_d [ROW_LEN];
    logic             div_start_q, div_start_d;
    logic             prob_vld_q, prob_vld_d;
    logic             prob_last_q, prob_last_d;
    logic [D_W-1:0]   prob_data_q, prob_data_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        divisor_d   = divisor_q;
        exp_buf_d   = exp_buf_q;
        div_start_d = div_start_q;
        prob_vld_d  = 1'b0;
        prob_last_d = 1'b0;
        prob_data_d = '0;
        sum_acc     = sum_q + SUM_W'(I_EXP_DATA);

        case (state_q)
            S_LOAD: begin
                if (I_EXP_VLD) begin
                    exp_buf_d[idx_q] = I_EXP_DATA;
                    if (idx_q == LAST_IDX) begin
                        idx_d     = '0;
                        sum_d     = '0;
                        divisor_d = (sum_acc > SAT_MAX) ? D_W'(SAT_MAX) : D_W'(sum_acc);
                        // A zero row cannot be divided; its first zero pulse is issued now.
                        if (sum_acc == '0) begin
                            state_d    = S_ZERO;
                            prob_vld_d = 1'b1;
                        end else begin
                            state_d     = S_REQ;
                            div_start_d = 1'b1;
                        end
                    end else begin
                        sum_d = sum_acc;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (I_DIV_VLD) begin
                    state_d     = S_GAP;
                    div_start_d = 1'b0;
                    prob_vld_d  = 1'b1;
                    prob_data_d = I_QUOTIENT;
                    prob_last_d = (idx_q == LAST_IDX);
                end
            end
            S_GAP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end else begin
                    state_d     = S_REQ;
                    idx_d       = idx_q + IDX_W'(1);
                    div_start_d = 1'b1;
                end
            end
            S_ZERO: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end else begin
                    prob_vld_d  = 1'b1;
                    prob_last_d = (idx_q == PENULT_IDX);
                    idx_d       = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            sum_q       <= '0;
            divisor_q   <= '0;
            div_start_q <= 1'b0;
            prob_vld_q  <= 1'b0;
            prob_last_q <= 1'b0;
            prob_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            divisor_q   <= divisor_d;
            div_start_q <= div_start_d;
            prob_vld_q  <= prob_vld_d;
            prob_last_q <= prob_last_d;
            prob_data_q <= prob_data_d;
        end
    end

    // Row buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge I_CLK) begin
        exp_buf_q <= exp_buf_d;
    end

    assign O_EXP_RDY   = (state_q == S_LOAD);
    assign O_DIV_START = div_start_q;
    assign O_DIVIDEND  = div_start_q ? exp_buf_q[idx_q] : '0;
    assign O_DIVISOR   = div_start_q ? divisor_q : '0;
    assign O_PROB_VLD  = prob_vld_q;
    assign O_PROB_DATA = prob_data_q;
    assign O_PROB_LAST = prob_last_q;
    assign O_BUSY      = !((state_q == S_LOAD) && (idx_q == '0));
endmodule

// File: tb/tb_softmax_norm_ctrl.sv
// Scoreboard bench for softmax_norm_ctrl: a row-level reference model queues expected
// divider operands and probabilities; a divider model and an output monitor consume them.
module tb_softmax_norm_ctrl;
    localparam int D_W     = 16;
    localparam int ROW_LEN = 4;

    logic           I_CLK = 1'b0;
    logic           I_RST;
    logic           I_EXP_VLD;
    logic [D_W-1:0] I_EXP_DATA;
    logic           O_EXP_RDY;
    logic           O_DIV_START;
    logic [D_W-1:0] O_DIVIDEND;
    logic [D_W-1:0] O_DIVISOR;
    logic           I_DIV_VLD;
    logic [D_W-1:0] I_QUOTIENT;
    logic           O_PROB_VLD;
    logic [D_W-1:0] O_PROB_DATA;
    logic           O_PROB_LAST;
    logic           O_BUSY;

    softmax_norm_ctrl #(.D_W(D_W), .ROW_LEN(ROW_LEN)) dut (
        .I_CLK(I_CLK), .I_RST(I_RST),
        .I_EXP_VLD(I_EXP_VLD), .I_EXP_DATA(I_EXP_DATA), .O_EXP_RDY(O_EXP_RDY),
        .O_DIV_START(O_DIV_START), .O_DIVIDEND(O_DIVIDEND), .O_DIVISOR(O_DIVISOR),
        .I_DIV_VLD(I_DIV_VLD), .I_QUOTIENT(I_QUOTIENT),
        .O_PROB_VLD(O_PROB_VLD), .O_PROB_DATA(O_PROB_DATA), .O_PROB_LAST(O_PROB_LAST),
        .O_BUSY(O_BUSY)
    );

    always #5 I_CLK = ~I_CLK;

    typedef struct {
        logic [D_W-1:0] dividend;
        logic [D_W-1:0] divisor;
    } div_exp_t;

    typedef struct {
        logic [D_W-1:0] data;
        logic           last;
    } prob_exp_t;

    div_exp_t  div_q[$];
    prob_exp_t prob_q[$];
    int        checks = 0;
    int        failures = 0;
    int        fixed_lat = 0;
    int        div_count = 0;
    bit        abort_pending = 1'b0;

    // Divider stand-in: quotient in Q13 fixed point (0.25 -> 0x0800).
    function automatic logic [D_W-1:0] div_model(input logic [D_W-1:0] n, input logic [D_W-1:0] d);
        longint q;
        if (d == '0) return '1;
        q = (longint'(n) * 64'd8192) / longint'(d);
        return q[D_W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Feeds one row, only counting beats that land while ready is high; optional junk
    // beats are driven while the block is busy and must be ignored by it.
    task automatic applyStimulus(input logic [D_W-1:0] row [ROW_LEN], input bit junk);
        int     sent = 0;
        int     guard = 0;
        longint sum = 0;
        logic [D_W-1:0] divisor;
        while (sent < ROW_LEN) begin
            @(negedge I_CLK); #1;
            guard++;
            if (guard > 1000) begin
                I_EXP_VLD = 1'b0;
                checkOutput("load_timeout", sent, ROW_LEN);
                return;
            end
            if (O_EXP_RDY) begin
                if ($urandom_range(0, 3) == 0) begin
                    I_EXP_VLD = 1'b0;
                end else begin
                    I_EXP_VLD  = 1'b1;
                    I_EXP_DATA = row[sent];
                    sent++;
                end
            end else begin
                I_EXP_VLD  = junk;
                I_EXP_DATA = D_W'($urandom_range(1, 16'h7FFF));
            end
        end
        for (int i = 0; i < ROW_LEN; i++) sum += longint'(row[i]);
        divisor = (sum > 32767) ? 16'h7FFF : D_W'(sum);
        for (int i = 0; i < ROW_LEN; i++) begin
            if (sum == 0) begin
                prob_q.push_back('{data: '0, last: (i == ROW_LEN - 1)});
            end else begin
                div_q.push_back('{dividend: row[i], divisor: divisor});
                prob_q.push_back('{data: div_model(row[i], divisor), last: (i == ROW_LEN - 1)});
            end
        end
        @(negedge I_CLK); #1;
        I_EXP_VLD = 1'b0;
    endtask

    // Divider model: latches operands when start rises, demands they stay stable,
    // pulses the quotient after a latency, and expects exactly one low start cycle.
    // It ignores aborts, so an aborted division still produces a stray valid pulse.
    initial begin
        bit             busy = 1'b0;
        bit             gap_pending = 1'b0;
        bit             gap_expect_high = 1'b0;
        int             cnt = 0;
        int             lat = 2;
        logic [D_W-1:0] cap_n = '0;
        logic [D_W-1:0] cap_d = '0;
        div_exp_t       e;
        I_DIV_VLD  = 1'b0;
        I_QUOTIENT = '0;
        forever begin
            @(negedge I_CLK);
            if (I_DIV_VLD) begin
                I_DIV_VLD  = 1'b0;
                I_QUOTIENT = '0;
                checkOutput("start_drop_after_vld", O_DIV_START, 0);
                gap_pending     = 1'b1;
                gap_expect_high = (div_q.size() > 0);
                abort_pending   = 1'b0;
            end else begin
                if (gap_pending) begin
                    gap_pending = 1'b0;
                    checkOutput("gap_one_cycle", O_DIV_START, gap_expect_high);
                end
                if (!busy) begin
                    if (O_DIV_START) begin
                        if (div_q.size() == 0) begin
                            checkOutput("unexpected_start", 1, 0);
                            cap_n = O_DIVIDEND;
                            cap_d = O_DIVISOR;
                        end else begin
                            e = div_q.pop_front();
                            checkOutput("dividend", O_DIVIDEND, e.dividend);
                            checkOutput("divisor", O_DIVISOR, e.divisor);
                            cap_n = e.dividend;
                            cap_d = e.divisor;
                        end
                        busy = 1'b1;
                        cnt  = 1;
                        lat  = (fixed_lat != 0) ? fixed_lat : $urandom_range(2, 5);
                        div_count++;
                    end
                end else begin
                    if (!abort_pending) begin
                        checkOutput("start_held", O_DIV_START, 1);
                        checkOutput("dividend_stable", O_DIVIDEND, cap_n);
                        checkOutput("divisor_stable", O_DIVISOR, cap_d);
                    end
                    cnt++;
                    if (cnt >= lat) begin
                        I_DIV_VLD  = 1'b1;
                        I_QUOTIENT = div_model(cap_n, cap_d);
                        busy       = 1'b0;
                    end
                end
            end
        end
    end

    // Output monitor: every probability pulse is matched against the scoreboard.
    initial begin
        bit        rdy_pending = 1'b0;
        prob_exp_t p;
        forever begin
            @(negedge I_CLK);
            if (rdy_pending) begin
                rdy_pending = 1'b0;
                checkOutput("rdy_after_last", O_EXP_RDY, 1);
            end
            if (!O_DIV_START) begin
                checkOutput("dividend_idle", O_DIVIDEND, 0);
                checkOutput("divisor_idle", O_DIVISOR, 0);
            end
            if (O_PROB_VLD) begin
                if (prob_q.size() == 0) begin
                    checkOutput("unexpected_prob", 1, 0);
                end else begin
                    p = prob_q.pop_front();
                    checkOutput("prob_data", O_PROB_DATA, p.data);
                    checkOutput("prob_last", O_PROB_LAST, p.last);
                    rdy_pending = p.last && !I_RST;
                end
            end else begin
                checkOutput("last_without_vld", O_PROB_LAST, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [D_W-1:0] row [ROW_LEN];
        int             base;
        int             guard;
        I_RST      = 1'b1;
        I_EXP_VLD  = 1'b0;
        I_EXP_DATA = '0;
        repeat (3) @(negedge I_CLK);
        checkOutput("reset_rdy", O_EXP_RDY, 1);
        checkOutput("reset_busy", O_BUSY, 0);
        checkOutput("reset_start", O_DIV_START, 0);
        checkOutput("reset_prob_vld", O_PROB_VLD, 0);
        checkOutput("reset_prob_data", O_PROB_DATA, 0);
        #1 I_RST = 1'b0;

        $display("[TB] equal row of 0x0100");
        for (int i = 0; i < ROW_LEN; i++) row[i] = 16'h0100;
        applyStimulus(row, 1'b0);
        $display("[TB] saturating row of 0x7000");
        for (int i = 0; i < ROW_LEN; i++) row[i] = 16'h7000;
        applyStimulus(row, 1'b1);
        $display("[TB] all-zero row");
        for (int i = 0; i < ROW_LEN; i++) row[i] = '0;
        applyStimulus(row, 1'b1);
        $display("[TB] row 1,2,3,4 with fixed 4-cycle divider");
        fixed_lat = 4;
        for (int i = 0; i < ROW_LEN; i++) row[i] = D_W'(i + 1);
        applyStimulus(row, 1'b1);

        $display("[TB] reset during second division");
        for (int i = 0; i < ROW_LEN; i++) row[i] = D_W'($urandom_range(1, 16'h7FFF));
        applyStimulus(row, 1'b1);
        fixed_lat = 0;
        base  = div_count;
        guard = 0;
        while ((div_count - base) < 1 && guard < 200) begin
            @(negedge I_CLK); #1;
            guard++;
        end
        while ((div_count - base) < 2 && guard < 200) begin
            @(negedge I_CLK); #1;
            guard++;
        end
        checkOutput("reset_test_reach", ((div_count - base) >= 2), 1);
        @(negedge I_CLK); #1;
        abort_pending = 1'b1;
        I_RST = 1'b1;
        div_q.delete();
        prob_q.delete();
        @(negedge I_CLK);
        checkOutput("abort_start", O_DIV_START, 0);
        checkOutput("abort_rdy", O_EXP_RDY, 1);
        checkOutput("abort_prob_vld", O_PROB_VLD, 0);
        #1 I_RST = 1'b0;
        repeat (8) @(negedge I_CLK);
        #1 abort_pending = 1'b0;

        $display("[TB] randomized rows");
        for (int r = 0; r < 20; r++) begin
            int mode = $urandom_range(0, 7);
            for (int i = 0; i < ROW_LEN; i++) begin
                if (mode == 0)      row[i] = '0;
                else if (mode < 4)  row[i] = D_W'($urandom_range(0, 255));
                else                row[i] = D_W'($urandom_range(0, 16'h7FFF));
            end
            applyStimulus(row, $urandom_range(0, 1) == 1);
        end

        guard = 0;
        while ((div_q.size() != 0 || prob_q.size() != 0 || O_BUSY) && guard < 2000) begin
            @(negedge I_CLK);
            guard++;
        end
        checkOutput("drain_div", div_q.size(), 0);
        checkOutput("drain_prob", prob_q.size(), 0);
        checkOutput("drain_idle_rdy", O_EXP_RDY, 1);
        repeat (4) @(negedge I_CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/softmax_norm_ctrl.md
SOFTMAX_NORM_CTRL -- requirements
Module: softmax_norm_ctrl

Interface
REQ-001 Parameter D_W, default 16, data width of exp values, divider operands and probabilities.
REQ-002 Parameter ROW_LEN, default 8, exp values per softmax row; power of two, range 2..64.
REQ-003 Parameter SUM_W, default D_W+$clog2(ROW_LEN), internal accumulator width.
REQ-004 I_CLK  in  1  sole clock; all logic on posedge.
REQ-005 I_RST  in  1  reset, synchronous, active-high.
REQ-006 I_EXP_VLD  in  1  exp value valid.
REQ-007 I_EXP_DATA  in  D_W  non-negative exp value; MSB always 0.
REQ-008 O_EXP_RDY  out  1  block accepts an exp value this cycle.
REQ-009 O_DIV_START  out  1  divider start/hold level; high for the whole of one division.
REQ-010 O_DIVIDEND  out  D_W  divider numerator, the buffered exp value.
REQ-011 O_DIVISOR  out  D_W  divider denominator, the saturated row sum.
REQ-012 I_DIV_VLD  in  1  divider one-cycle quotient valid pulse.
REQ-013 I_QUOTIENT  in  D_W  divider quotient.
REQ-014 O_PROB_VLD  out  1  one-cycle pulse per normalized output.
REQ-015 O_PROB_DATA  out  D_W  normalized probability.
REQ-016 O_PROB_LAST  out  1  high with the O_PROB_VLD pulse of the last element of a row.
REQ-017 O_BUSY  out  1  high in every state except S_LOAD with count 0.

Function
REQ-018 States: S_LOAD, S_REQ, S_WAIT, S_GAP, S_ZERO.
REQ-019 S_LOAD: O_EXP_RDY=1; each cycle with I_EXP_VLD=1 writes I_EXP_DATA to buf[idx], adds it to sum, and increments idx.
REQ-020 I_EXP_VLD with O_EXP_RDY=0 is ignored; the value is neither stored nor summed.
REQ-021 On the ROW_LEN-th accept, latch divisor = (sum including this value > 2^(D_W-1)-1) ? 2^(D_W-1)-1 : sum, reset idx to 0, and go to S_ZERO if the full sum is 0, else to S_REQ.
REQ-022 S_REQ: O_DIV_START=1, O_DIVIDEND=buf[idx], O_DIVISOR=latched divisor; go to S_WAIT next cycle.
REQ-023 S_WAIT: O_DIV_START stays 1; operands are held stable; remain until I_DIV_VLD=1.
REQ-024 When I_DIV_VLD=1 is sampled in S_WAIT: the next cycle O_PROB_VLD=1 and O_PROB_DATA=I_QUOTIENT (registered); O_PROB_LAST=1 if idx==ROW_LEN-1; O_DIV_START=0; go to S_GAP.
REQ-025 S_GAP lasts exactly one cycle with O_DIV_START=0, so the divider returns to idle. Then idx increments and the block goes to S_REQ, or to S_LOAD after the last element.
REQ-026 Each element's division sequence is: start rises in S_REQ, stays high through S_WAIT, and drops in S_GAP; start never toggles mid-division.
REQ-027 I_DIV_VLD outside S_WAIT is ignored.
REQ-028 S_ZERO emits ROW_LEN consecutive pulses with O_PROB_DATA=0 and O_PROB_LAST on the final pulse, never asserts O_DIV_START, then goes to S_LOAD.
REQ-029 Accumulator is SUM_W bits unsigned and cannot overflow; saturation happens only when forming the divisor.
REQ-030 Outputs are emitted in input order; no backpressure on the O_PROB_* stream.
REQ-031 O_PROB_VLD, O_PROB_LAST and O_DIV_START are registered; O_DIVIDEND and O_DIVISOR are 0 whenever O_DIV_START=0.
REQ-032 In S_LOAD, the cycle after the last output pulse, O_EXP_RDY=1 and a new row is accepted at once.

Reset
REQ-033 I_RST=1 at a clock edge sets state S_LOAD, idx 0, sum 0, divisor 0, and all outputs 0 except O_EXP_RDY=1; the buffer contents are don't-care.
REQ-034 Reset during S_WAIT drops O_DIV_START the next cycle, which aborts the in-flight division; a later I_DIV_VLD is ignored.
REQ-035 Reset has priority over every other event in the same cycle.

Verification
REQ-036 ROW_LEN=4; exps 0x0100 x4 back-to-back -> each division presents O_DIVIDEND=0x0100, O_DIVISOR=0x0400; model quotient 0x0800 -> 4 O_PROB_VLD pulses of 0x0800, LAST on the 4th.
REQ-037 ROW_LEN=4; exps 0x7000 x4 -> O_DIVISOR=0x7FFF (saturated), O_DIVIDEND=0x7000 for each division.
REQ-038 All-zero row -> no O_DIV_START ever; 4 consecutive pulses of 0x0000, LAST on the 4th, then O_EXP_RDY=1.
REQ-039 Divider model with 4-cycle latency -> O_DIV_START high from S_REQ until the cycle after I_DIV_VLD; exactly 1 low cycle between divisions; exps 1,2,3,4 output in order.
REQ-040 I_RST pulsed during the 2nd division's S_WAIT -> next cycle O_DIV_START=0, O_EXP_RDY=1, no O_PROB_VLD; a fresh row then completes normally.
REQ-041 I_EXP_VLD asserted during S_WAIT and S_GAP -> values are not accepted; the sum and the next row are unaffected.
